ex_flag_stage: RTL and testbench

Execute-stage back end sitting directly downstream of the `au` arithmetic unit. Each cycle it registers the `au` result into the EX/MEM boundary and maintains the processor's Z/V/N flag register from the `au` status outputs. It also resolves conditional branches against the committed flags. It implements stall and flush semantics so that the pipeline control can hold or squash the stage.

---
 rtl/ex_flag_stage.sv | 108 ++++++++++
 tb/tb_ex_flag_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ex_flag_stage.sv
// EX/MEM boundary register with Z/V/N flag maintenance and branch resolution.
// Optional sticky overflow bit is built only when EXF_STICKY_OVF_EN is defined.
module ex_flag_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] au_result,
    input  logic             au_v,
    input  logic             au_n,
    input  logic             in_valid,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       ccc,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] out_result,
    output logic             out_valid,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             br_valid,
    output logic             br_taken,
    output logic             ovf_sticky
);

    localparam logic [1:0] KIND_ARITH  = 2'b00;
    localparam logic [1:0] KIND_LOGIC  = 2'b01;
    localparam logic [1:0] KIND_BRANCH = 2'b10;

    // Valid semantics: in_valid qualifies the inputs in the cycle it is high;
    // the instruction is consumed only when acc is high. There is no ready.
    // out_valid / br_valid qualify the outputs for the cycle after an edge.
    logic acc;
    logic res_zero;
    logic cond;

    assign acc      = in_valid & ~stall & ~flush;
    assign res_zero = (au_result == '0);

    // Condition is evaluated on the committed flags, before this edge updates them.
    always_comb begin
        cond = 1'b0;
        case (ccc)
            3'b000:  cond = ~flag_z;
            3'b001:  cond = flag_z;
            3'b010:  cond = ~flag_z & ~flag_n;
            3'b011:  cond = flag_n;
            3'b100:  cond = flag_z | ~flag_n;
            3'b101:  cond = flag_z | flag_n;
            3'b110:  cond = flag_v;
            default: cond = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_result <= '0;
            out_valid  <= 1'b0;
            flag_z     <= 1'b0;
            flag_v     <= 1'b0;
            flag_n     <= 1'b0;
            br_valid   <= 1'b0;
            br_taken   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            br_valid  <= 1'b0;
            br_taken  <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            br_valid  <= in_valid & (in_kind == KIND_BRANCH);
            br_taken  <= in_valid & (in_kind == KIND_BRANCH) & cond;
            if (in_valid) begin
                out_result <= au_result;
                if (in_kind == KIND_ARITH) begin
                    flag_z <= res_zero;
                    flag_v <= au_v;
                    flag_n <= au_n;
                end else if (in_kind == KIND_LOGIC) begin
                    flag_z <= res_zero;
                end
            end
        end
    end

`ifdef EXF_STICKY_OVF_EN
    logic sticky_q;

    // Set has priority over clear; stall and flush freeze the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (acc && in_kind == KIND_ARITH && au_v) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky && !stall && !flush) begin
            sticky_q <= 1'b0;
        end
    end

    assign ovf_sticky = sticky_q;
`else
    logic unused_clr;

    assign unused_clr = clr_sticky;
    assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed-vector bench for ex_flag_stage: driver pushes hand-computed expected
// outputs into a queue, a monitor pops and compares one cycle later.
module tb_ex_flag_stage;

    localparam int WIDTH = 16;
    localparam int PW    = WIDTH + 7;
`ifdef EXF_STICKY_OVF_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] au_result;
    logic             au_v;
    logic             au_n;
    logic             in_valid;
    logic [1:0]       in_kind;
    logic [2:0]       ccc;
    logic             stall;
    logic             flush;
    logic             clr_sticky;
    logic [WIDTH-1:0] out_result;
    logic             out_valid;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;
    logic             br_valid;
    logic             br_taken;
    logic             ovf_sticky;

    logic [PW-1:0] exp_q[$];
    string         name_q[$];
    int            checks;
    int            failures;

    ex_flag_stage #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .au_result  (au_result),
        .au_v       (au_v),
        .au_n       (au_n),
        .in_valid   (in_valid),
        .in_kind    (in_kind),
        .ccc        (ccc),
        .stall      (stall),
        .flush      (flush),
        .clr_sticky (clr_sticky),
        .out_result (out_result),
        .out_valid  (out_valid),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_n     (flag_n),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .ovf_sticky (ovf_sticky)
    );

    // Clock and reset-time defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PW-1:0] pk(input logic [WIDTH-1:0] res, input logic ov,
                                         input logic z, input logic v, input logic n,
                                         input logic bv, input logic bt, input logic st);
        return {res, ov, z, v, n, bv, bt, st};
    endfunction

    // Driver: applies one cycle of inputs 3 time units after an edge and
    // records what the outputs must be after the following edge.
    task automatic step(input string name, input logic rst, input logic vld,
                        input logic [1:0] kind, input logic [2:0] cc,
                        input logic stl, input logic fl, input logic clr,
                        input logic [WIDTH-1:0] res, input logic v, input logic n,
                        input logic [PW-1:0] exp);
        @(posedge clk);
        #3;
        rst_n      = rst;
        in_valid   = vld;
        in_kind    = kind;
        ccc        = cc;
        stall      = stl;
        flush      = fl;
        clr_sticky = clr;
        au_result  = res;
        au_v       = v;
        au_n       = n;
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // Monitor: compares 2 time units after every edge
    initial begin
        logic [PW-1:0] act;
        logic [PW-1:0] exp;
        string         nm;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {out_result, out_valid, flag_z, flag_v, flag_n, br_valid, br_taken, ovf_sticky};
                checks++;
                if (act !== exp) begin
                    failures++;
                    $display("FAIL %s: got res=%h ov=%b zvn=%b%b%b bv=%b bt=%b st=%b, want res=%h ov=%b zvn=%b%b%b bv=%b bt=%b st=%b",
                             nm, act[PW-1:7], act[6], act[5], act[4], act[3], act[2], act[1], act[0],
                             exp[PW-1:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
    end

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_kind    = 2'b00;
        ccc        = 3'b000;
        stall      = 1'b0;
        flush      = 1'b0;
        clr_sticky = 1'b0;
        au_result  = '0;
        au_v       = 1'b0;
        au_n       = 1'b0;

        //    name           rst vld kind   ccc    stl fl  clr res       v  n   expected outputs
        step("reset_busy",   0, 1, 2'b10, 3'b111, 1, 0, 0, 16'hFFFF, 1, 1, pk(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        step("reset_idle",   0, 0, 2'b00, 3'b000, 0, 0, 0, 16'h0000, 0, 0, pk(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        step("sat_add",      1, 1, 2'b00, 3'b000, 0, 0, 0, 16'h8000, 1, 1, pk(16'h8000, 1, 0, 1, 1, 0, 0, STK));
        step("br_ovfl",      1, 1, 2'b10, 3'b110, 0, 0, 0, 16'h0005, 0, 0, pk(16'h0005, 1, 0, 1, 1, 1, 1, STK));
        step("logic_zero",   1, 1, 2'b01, 3'b000, 0, 0, 0, 16'h0000, 0, 0, pk(16'h0000, 1, 1, 1, 1, 0, 0, STK));
        step("br_eq",        1, 1, 2'b10, 3'b001, 0, 0, 0, 16'h0000, 0, 0, pk(16'h0000, 1, 1, 1, 1, 1, 1, STK));
        step("br_neq",       1, 1, 2'b10, 3'b000, 0, 0, 0, 16'h0000, 0, 0, pk(16'h0000, 1, 1, 1, 1, 1, 0, STK));
        step("sub_7fff",     1, 1, 2'b00, 3'b000, 0, 0, 0, 16'h7FFF, 1, 0, pk(16'h7FFF, 1, 0, 1, 0, 0, 0, STK));
        step("br_gt",        1, 1, 2'b10, 3'b010, 0, 0, 0, 16'h7FFF, 0, 0, pk(16'h7FFF, 1, 0, 1, 0, 1, 1, STK));
        step("br_gte",       1, 1, 2'b10, 3'b100, 0, 0, 0, 16'h7FFF, 0, 0, pk(16'h7FFF, 1, 0, 1, 0, 1, 1, STK));
        step("br_lt",        1, 1, 2'b10, 3'b011, 0, 0, 0, 16'h7FFF, 0, 0, pk(16'h7FFF, 1, 0, 1, 0, 1, 0, STK));
        step("br_lte",       1, 1, 2'b10, 3'b101, 0, 0, 0, 16'h7FFF, 0, 0, pk(16'h7FFF, 1, 0, 1, 0, 1, 0, STK));
        step("br_uncond",    1, 1, 2'b10, 3'b111, 0, 0, 0, 16'h7FFF, 0, 0, pk(16'h7FFF, 1, 0, 1, 0, 1, 1, STK));
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", 1, 1, 2'b00, 3'b000, 1, 0, 0, 16'h1234, 0, 0, pk(16'h7FFF, 1, 0, 1, 0, 1, 1, STK));
        end
        step("after_stall",  1, 1, 2'b00, 3'b000, 0, 0, 0, 16'h1234, 0, 0, pk(16'h1234, 1, 0, 0, 0, 0, 0, STK));
        step("flush_stall",  1, 1, 2'b00, 3'b000, 1, 1, 0, 16'h0000, 1, 1, pk(16'h1234, 0, 0, 0, 0, 0, 0, STK));
        step("br_ovfl_clr",  1, 1, 2'b10, 3'b110, 0, 0, 0, 16'h00AA, 0, 0, pk(16'h00AA, 1, 0, 0, 0, 1, 0, STK));
        step("flush_branch", 1, 1, 2'b10, 3'b111, 0, 1, 0, 16'h0000, 0, 0, pk(16'h00AA, 0, 0, 0, 0, 0, 0, STK));
        step("idle",         1, 0, 2'b00, 3'b000, 0, 0, 0, 16'h5555, 1, 1, pk(16'h00AA, 0, 0, 0, 0, 0, 0, STK));
        step("clr_sticky",   1, 0, 2'b00, 3'b000, 0, 0, 1, 16'h0000, 0, 0, pk(16'h00AA, 0, 0, 0, 0, 0, 0, 0));
        step("set_beats_clr",1, 1, 2'b00, 3'b000, 0, 0, 1, 16'h8000, 1, 1, pk(16'h8000, 1, 0, 1, 1, 0, 0, STK));
        step("br_pre_reset", 1, 1, 2'b10, 3'b111, 0, 0, 0, 16'h0001, 0, 0, pk(16'h0001, 1, 0, 1, 1, 1, 1, STK));
        step("reset_mid",    0, 1, 2'b10, 3'b111, 1, 0, 0, 16'h0002, 0, 0, pk(16'h0000, 0, 0, 0, 0, 0, 0, 0));
        step("br_eq_post",   1, 1, 2'b10, 3'b001, 0, 0, 0, 16'h0002, 0, 0, pk(16'h0002, 1, 0, 0, 0, 1, 0, 0));
        step("arith_zero",   1, 1, 2'b00, 3'b000, 0, 0, 0, 16'h0000, 0, 0, pk(16'h0000, 1, 1, 0, 0, 0, 0, 0));
        step("other_kind",   1, 1, 2'b11, 3'b000, 0, 0, 0, 16'h00F0, 1, 1, pk(16'h00F0, 1, 1, 0, 0, 0, 0, 0));

        // Bounded drain of the expected queue
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #4;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
